// File: rtl/break_eval_sequencer.sv
// rtl/break_eval_sequencer.sv - per-literal break evaluation sequencer for one broken clause
module break_eval_sequencer #(
  parameter int NSAT                     = 3,
  parameter int NSAT_BITS                = 2,
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int VAR_BITS                 = 12,
  parameter int BVC_LATENCY              = 1,
  parameter int SEL_LATENCY              = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_i,
  input  logic [NSAT*VAR_BITS-1:0]            clause_vars_i,
  output logic                                ready_o,
  output logic                                mem_rd_o,
  output logic [VAR_BITS-1:0]                 mem_addr_o,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_broken_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] mem_mask_i,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_broken_o,
  output logic [MAX_CLAUSES_PER_VARIABLE-1:0] mask_bits_o,
  output logic [NSAT-1:0]                     break_values_valid_o,
  output logic [NSAT_BITS-1:0]                wren_o,
  input  logic [NSAT_BITS-1:0]                select_i,
  output logic                                done_o,
  output logic [VAR_BITS-1:0]                 flip_var_o,
  output logic [NSAT_BITS-1:0]                flip_slot_o
);

  localparam int MC        = MAX_CLAUSES_PER_VARIABLE;
  // Slot tag travels from fetch through memory, data register and counter latency.
  localparam int TAG_DEPTH = 2 + BVC_LATENCY;
  localparam int SEL_CW    = $clog2(SEL_LATENCY + 2);
  localparam logic [NSAT_BITS-1:0] WREN_SEL  = '1;
  localparam logic [NSAT_BITS-1:0] LAST_SLOT = NSAT_BITS'(NSAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_SEL, DONE} state_t;

  state_t                              state_q, state_d;
  logic [NSAT*VAR_BITS-1:0]            vars_q, vars_d;
  logic [TAG_DEPTH-1:0]                tag_vld_q, tag_vld_d;
  logic [TAG_DEPTH-1:0][NSAT_BITS-1:0] tag_q, tag_d;
  logic                                rd_dly_q, rd_dly_d;
  logic                                mem_rd_q, mem_rd_d;
  logic [VAR_BITS-1:0]                 mem_addr_q, mem_addr_d;
  logic [MC-1:0]                       clause_broken_q, clause_broken_d;
  logic [MC-1:0]                       mask_bits_q, mask_bits_d;
  logic [NSAT-1:0]                     bvv_q, bvv_d;
  logic [NSAT_BITS-1:0]                wren_q, wren_d;
  logic [SEL_CW-1:0]                   sel_cnt_q, sel_cnt_d;
  logic                                ready_q, ready_d;
  logic                                done_q, done_d;
  logic [VAR_BITS-1:0]                 flip_var_q, flip_var_d;
  logic [NSAT_BITS-1:0]                flip_slot_q, flip_slot_d;

  logic [NSAT-1:0]                     start_mask;
  logic                                sample_sel;

  // Variable ID held in a slot; indices past the last literal read as the empty ID.
  function automatic logic [VAR_BITS-1:0] slot_var(input logic [NSAT*VAR_BITS-1:0] vars,
                                                   input logic [NSAT_BITS-1:0] idx);
    logic [VAR_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < NSAT; k++) begin
      if (idx == NSAT_BITS'(k)) r = vars[k*VAR_BITS +: VAR_BITS];
    end
    return r;
  endfunction

  // Nonzero-slot mask of the incoming clause.
  always_comb begin
    start_mask = '0;
    for (int k = 0; k < NSAT; k++) begin
      start_mask[k] = |clause_vars_i[k*VAR_BITS +: VAR_BITS];
    end
  end

  // Sequencing: state, fetch issue, selection sampling.
  always_comb begin
    state_d     = state_q;
    vars_d      = vars_q;
    bvv_d       = bvv_q;
    sel_cnt_d   = sel_cnt_q;
    flip_var_d  = flip_var_q;
    flip_slot_d = flip_slot_q;
    sample_sel  = 1'b0;
    tag_vld_d   = {tag_vld_q[TAG_DEPTH-2:0], 1'b0};
    tag_d       = {tag_q[TAG_DEPTH-2:0], NSAT_BITS'(0)};

    case (state_q)
      IDLE: begin
        if (start_i) begin
          vars_d      = clause_vars_i;
          bvv_d       = start_mask;
          flip_var_d  = '0;
          flip_slot_d = '0;
          if (start_mask == '0) begin
            state_d = DONE;
          end else begin
            state_d      = RUN;
            tag_vld_d[0] = 1'b1;
            tag_d[0]     = '0;
          end
        end
      end
      RUN: begin
        if (tag_vld_q[0] && (tag_q[0] != LAST_SLOT)) begin
          tag_vld_d[0] = 1'b1;
          tag_d[0]     = tag_q[0] + 1'b1;
        end
        // The all-ones write-enable cycle is cycle zero of the selector latency count.
        if (wren_q == WREN_SEL) begin
          if (SEL_LATENCY == 0) begin
            sample_sel = 1'b1;
            state_d    = DONE;
          end else begin
            state_d   = WAIT_SEL;
            sel_cnt_d = SEL_CW'(1);
          end
        end
      end
      WAIT_SEL: begin
        if (sel_cnt_q == SEL_CW'(SEL_LATENCY)) begin
          sample_sel = 1'b1;
          state_d    = DONE;
        end else begin
          sel_cnt_d = sel_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        bvv_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    if (sample_sel) begin
      flip_slot_d = select_i;
      flip_var_d  = slot_var(vars_q, select_i);
    end

    // Empty slots still occupy a fetch cycle but issue no read.
    mem_addr_d = tag_vld_d[0] ? slot_var(vars_d, tag_d[0]) : '0;
    mem_rd_d   = tag_vld_d[0] && (mem_addr_d != '0);
    ready_d    = (state_d == IDLE);
    done_d     = (state_d == DONE);
  end

  // Memory return capture and write-enable generation from emerging tags.
  always_comb begin
    rd_dly_d        = mem_rd_q;
    clause_broken_d = clause_broken_q;
    mask_bits_d     = mask_bits_q;
    if (tag_vld_q[1]) begin
      clause_broken_d = rd_dly_q ? mem_broken_i : '0;
      mask_bits_d     = rd_dly_q ? mem_mask_i : '0;
    end
    wren_d = '0;
    if (tag_vld_q[TAG_DEPTH-1]) begin
      if (tag_q[TAG_DEPTH-1] == LAST_SLOT) wren_d = WREN_SEL;
      else                                 wren_d = NSAT_BITS'(1) << tag_q[TAG_DEPTH-1];
    end
  end

  // State and output registers; reset flushes the tag pipeline so no wren escapes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      vars_q          <= '0;
      tag_vld_q       <= '0;
      tag_q           <= '0;
      rd_dly_q        <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_addr_q      <= '0;
      clause_broken_q <= '0;
      mask_bits_q     <= '0;
      bvv_q           <= '0;
      wren_q          <= '0;
      sel_cnt_q       <= '0;
      ready_q         <= 1'b1;
      done_q          <= 1'b0;
      flip_var_q      <= '0;
      flip_slot_q     <= '0;
    end else begin
      state_q         <= state_d;
      vars_q          <= vars_d;
      tag_vld_q       <= tag_vld_d;
      tag_q           <= tag_d;
      rd_dly_q        <= rd_dly_d;
      mem_rd_q        <= mem_rd_d;
      mem_addr_q      <= mem_addr_d;
      clause_broken_q <= clause_broken_d;
      mask_bits_q     <= mask_bits_d;
      bvv_q           <= bvv_d;
      wren_q          <= wren_d;
      sel_cnt_q       <= sel_cnt_d;
      ready_q         <= ready_d;
      done_q          <= done_d;
      flip_var_q      <= flip_var_d;
      flip_slot_q     <= flip_slot_d;
    end
  end

  assign ready_o              = ready_q;
  assign mem_rd_o             = mem_rd_q;
  assign mem_addr_o           = mem_addr_q;
  assign clause_broken_o      = clause_broken_q;
  assign mask_bits_o          = mask_bits_q;
  assign break_values_valid_o = bvv_q;
  assign wren_o               = wren_q;
  assign done_o               = done_q;
  assign flip_var_o           = flip_var_q;
  assign flip_slot_o          = flip_slot_q;

endmodule

// File: tb/tb_break_eval_sequencer.sv
// tb/tb_break_eval_sequencer.sv - directed bench for break_eval_sequencer
module tb_break_eval_sequencer;
  localparam int NSAT = 3;
  localparam int NB   = 2;
  localparam int MC   = 20;
  localparam int VB   = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i;
  logic [NSAT*VB-1:0] clause_vars_i;
  logic [MC-1:0]    mem_broken_i, mem_mask_i;
  logic [NB-1:0]    select_i;

  logic             ready_o, mem_rd_o, done_o;
  logic [VB-1:0]    mem_addr_o, flip_var_o;
  logic [MC-1:0]    clause_broken_o, mask_bits_o;
  logic [NSAT-1:0]  bvv_o;
  logic [NB-1:0]    wren_o, flip_slot_o;

  logic             b_ready_o, b_mem_rd_o, b_done_o;
  logic [VB-1:0]    b_mem_addr_o, b_flip_var_o;
  logic [MC-1:0]    b_clause_broken_o, b_mask_bits_o;
  logic [NSAT-1:0]  b_bvv_o;
  logic [NB-1:0]    b_wren_o, b_flip_slot_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [VB-1:0]   v0;
    logic [VB-1:0]   v1;
    logic [VB-1:0]   v2;
    logic [NB-1:0]   sel;
    logic [NSAT-1:0] exp_mask;
    logic [VB-1:0]   exp_var;
    logic [NB-1:0]   exp_slot;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  break_eval_sequencer #(.SEL_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .clause_vars_i(clause_vars_i),
    .ready_o(ready_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
    .mem_broken_i(mem_broken_i), .mem_mask_i(mem_mask_i),
    .clause_broken_o(clause_broken_o), .mask_bits_o(mask_bits_o),
    .break_values_valid_o(bvv_o), .wren_o(wren_o), .select_i(select_i),
    .done_o(done_o), .flip_var_o(flip_var_o), .flip_slot_o(flip_slot_o)
  );

  break_eval_sequencer #(.SEL_LATENCY(2)) dut_sl2 (
    .clk(clk), .reset(reset), .start_i(start_i), .clause_vars_i(clause_vars_i),
    .ready_o(b_ready_o), .mem_rd_o(b_mem_rd_o), .mem_addr_o(b_mem_addr_o),
    .mem_broken_i(mem_broken_i), .mem_mask_i(mem_mask_i),
    .clause_broken_o(b_clause_broken_o), .mask_bits_o(b_mask_bits_o),
    .break_values_valid_o(b_bvv_o), .wren_o(b_wren_o), .select_i(select_i),
    .done_o(b_done_o), .flip_var_o(b_flip_var_o), .flip_slot_o(b_flip_slot_o)
  );

  function automatic logic [MC-1:0] pb(input logic [VB-1:0] a);
    return 20'h0F0F0 ^ {8'h00, a};
  endfunction

  function automatic logic [MC-1:0] pm(input logic [VB-1:0] a);
    return 20'hF00F0 ^ {a, 8'h00};
  endfunction

  // Occurrence memory: one-cycle read latency, garbage when not strobed.
  logic          rd_prev = 1'b0;
  logic [VB-1:0] addr_prev = '0;
  always @(posedge clk) begin
    rd_prev   <= mem_rd_o;
    addr_prev <= mem_addr_o;
  end
  assign mem_broken_i = rd_prev ? pb(addr_prev) : 20'hDEAD5;
  assign mem_mask_i   = rd_prev ? pm(addr_prev) : 20'hBEEF3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One full transaction from start acceptance (cycle 0) through cycle 9.
  task automatic run_txn(input vec_t r);
    logic [VB-1:0] va [NSAT];
    logic          empty;
    va[0] = r.v0;
    va[1] = r.v1;
    va[2] = r.v2;
    empty = (r.exp_mask == '0);
    start_i       = 1'b1;
    clause_vars_i = {r.v2, r.v1, r.v0};
    select_i      = ~r.sel;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start_i  = 1'b0;
      select_i = (c == 7) ? r.sel : ~r.sel;
      chk("ready", c, ready_o, empty ? (c >= 2) : (c >= 9));
      chk("done", c, done_o, empty ? (c == 1) : (c == 8));
      chk("bvv", c, bvv_o, (!empty && c <= 8) ? r.exp_mask : 3'b000);
      chk("wren", c, wren_o, empty ? 2'b00 : (c == 4) ? 2'b01 : (c == 5) ? 2'b10 : (c == 6) ? 2'b11 : 2'b00);
      if (!empty && c <= 3) begin
        chk("mem_rd", c, mem_rd_o, va[c-1] != '0);
        chk("mem_addr", c, mem_addr_o, va[c-1]);
      end else begin
        chk("mem_rd", c, mem_rd_o, 1'b0);
      end
      if (!empty && c >= 3 && c <= 5) begin
        chk("broken", c, clause_broken_o, (va[c-3] != '0) ? pb(va[c-3]) : 20'h0);
        chk("mask", c, mask_bits_o, (va[c-3] != '0) ? pm(va[c-3]) : 20'h0);
      end
      if (c == (empty ? 1 : 8) || (!empty && c == 9)) begin
        chk("flip_var", c, flip_var_o, r.exp_var);
        chk("flip_slot", c, flip_slot_o, r.exp_slot);
      end
    end
  endtask

  initial begin
    vecs[0] = '{12'd5, 12'd9,  12'd17,   2'd2, 3'b111, 12'd17, 2'd2};
    vecs[1] = '{12'd0, 12'd4,  12'd6,    2'd1, 3'b110, 12'd4,  2'd1};
    vecs[2] = '{12'd0, 12'd0,  12'd0,    2'd0, 3'b000, 12'd0,  2'd0};
    vecs[3] = '{12'd7, 12'd0,  12'd3,    2'd0, 3'b101, 12'd7,  2'd0};
    vecs[4] = '{12'd1, 12'd2,  12'd4095, 2'd3, 3'b111, 12'd0,  2'd3};

    reset = 1'b1;
    start_i = 1'b0;
    clause_vars_i = '0;
    select_i = '0;
    tick();
    tick();
    chk("rst ready", 0, ready_o, 1'b1);
    chk("rst mem_rd", 0, mem_rd_o, 1'b0);
    chk("rst mem_addr", 0, mem_addr_o, 12'd0);
    chk("rst broken", 0, clause_broken_o, 20'h0);
    chk("rst mask", 0, mask_bits_o, 20'h0);
    chk("rst bvv", 0, bvv_o, 3'b000);
    chk("rst wren", 0, wren_o, 2'b00);
    chk("rst done", 0, done_o, 1'b0);
    chk("rst flip_var", 0, flip_var_o, 12'd0);
    chk("rst flip_slot", 0, flip_slot_o, 2'd0);
    chk("rst sl2 ready", 0, b_ready_o, 1'b1);
    reset = 1'b0;
    tick();
    chk("idle ready", 0, ready_o, 1'b1);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Reset during cycle 5 of a run.
    start_i = 1'b1;
    clause_vars_i = {12'd17, 12'd9, 12'd5};
    select_i = 2'd2;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start_i = 1'b0;
    end
    chk("pre-rst wren", 5, wren_o, 2'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst bvv", 6, bvv_o, 3'b000);
    chk("midrst broken", 6, clause_broken_o, 20'h0);
    for (int c = 6; c <= 12; c++) begin
      if (c > 6) tick();
      chk("midrst wren", c, wren_o, 2'b00);
      chk("midrst done", c, done_o, 1'b0);
      chk("midrst ready", c, ready_o, 1'b1);
    end
    run_txn('{12'd3, 12'd0, 12'd8, 2'd0, 3'b101, 12'd3, 2'd0});

    // start_i held high: second clause accepted at cycle 9.
    start_i = 1'b1;
    clause_vars_i = {12'd17, 12'd9, 12'd5};
    select_i = 2'd2;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 10) start_i = 1'b0;
      if (c <= 8) chk("hold ready", c, ready_o, 1'b0);
      if (c == 8) chk("hold done1", c, done_o, 1'b1);
      if (c == 9) begin
        chk("hold ready9", c, ready_o, 1'b1);
        chk("hold mem_rd9", c, mem_rd_o, 1'b0);
      end
      if (c == 10) begin
        chk("hold ready10", c, ready_o, 1'b0);
        chk("hold mem_rd10", c, mem_rd_o, 1'b1);
        chk("hold addr10", c, mem_addr_o, 12'd5);
      end
      if (c == 17) begin
        chk("hold done2", c, done_o, 1'b1);
        chk("hold flip_var2", c, flip_var_o, 12'd17);
      end
      if (c == 18) chk("hold ready18", c, ready_o, 1'b1);
    end

    // Selector latency 2 instance samples at cycle 8, latency 1 at cycle 7.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start_i = 1'b1;
    clause_vars_i = {12'd17, 12'd9, 12'd5};
    select_i = 2'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_i = 1'b0;
      select_i = (c == 8) ? 2'd1 : 2'd2;
      if (c == 6) chk("sl2 wren6", c, b_wren_o, 2'b11);
      if (c == 7) chk("sl2 wren7", c, b_wren_o, 2'b00);
      chk("sl2 done", c, b_done_o, c == 9);
      chk("sl1 done", c, done_o, c == 8);
      if (c == 8) chk("sl1 flip_var", c, flip_var_o, 12'd17);
      if (c == 9) begin
        chk("sl2 flip_slot", c, b_flip_slot_o, 2'd1);
        chk("sl2 flip_var", c, b_flip_var_o, 12'd9);
      end
      if (c == 10) chk("sl2 ready", c, b_ready_o, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/break_eval_sequencer.md
# break_eval_sequencer

Sequences the per-literal break evaluation for one broken clause and sits directly upstream of the break-counter/selector stage. It fetches each literal's clause-occurrence bits from occurrence memory and streams them into the counter. It drives the one-hot / all-ones write-enable pattern, samples the heuristic selection, and reports which variable to flip to the flip/update stage.

## Interface
- NSAT, 3, literals per clause (≥2)
- NSAT_BITS, 2, width of slot index and write-enable; must equal NSAT-1 and satisfy 2^NSAT_BITS ≥ NSAT
- MAX_CLAUSES_PER_VARIABLE (MC), 20, occurrence slots per variable
- VAR_BITS, 12, variable ID width; ID 0 = empty literal slot
- BVC_LATENCY, 1, cycles from clause_broken_o/mask_bits_o to the counter's break value
- SEL_LATENCY, 1, cycles from the all-ones write-enable to a valid select_i
---
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start_i  in  1  request; accepted only when ready_o=1
- clause_vars_i  in  NSAT*VAR_BITS  variable IDs, slot k at [k*VAR_BITS +: VAR_BITS]
- ready_o  out  1  high only in IDLE
- mem_rd_o  out  1  occurrence-memory read strobe
- mem_addr_o  out  VAR_BITS  variable ID to read
- mem_broken_i  in  MC  would-break bits; valid exactly 1 cycle after mem_rd_o
- mem_mask_i  in  MC  valid-occurrence bits, same timing
- clause_broken_o  out  MC  registered, to counter
- mask_bits_o  out  MC  registered, to counter
- break_values_valid_o  out  NSAT  bit k = slot k nonzero
- wren_o  out  NSAT_BITS  0 = idle; one-hot bit k = store literal k; all ones = select
- select_i  in  NSAT_BITS  selected slot from heuristic selector
- done_o  out  1  1-cycle pulse, result valid
- flip_var_o  out  VAR_BITS  variable to flip; 0 = none
- flip_slot_o  out  NSAT_BITS  sampled select_i

## Operation
- States: IDLE, RUN, WAIT_SEL, DONE.
- IDLE, start_i=1: latch clause_vars_i; set break_values_valid_o to the nonzero mask of the slots.
  - Mask all zero: go to DONE with flip_var_o=0 and flip_slot_o=0; no reads, wren_o stays 0.
  - Otherwise go to RUN.
- RUN: fetch slots 0..NSAT-1 on consecutive cycles, with mem_addr_o = var[k].
  - Nonzero slot: mem_rd_o=1.
  - Zero slot: mem_rd_o=0, and the fetched data is forced to zeros.
- The returned data is registered onto clause_broken_o/mask_bits_o one cycle after it arrives.
- A tag pipeline of depth 2+BVC_LATENCY carries k for each slot.
  - When the tag for slot k<NSAT-1 emerges, wren_o = one-hot bit k.
  - When the tag for slot NSAT-1 emerges, wren_o = all ones for exactly 1 cycle.
- After the all-ones cycle, wren_o=0 (mandatory all-ones→zero transition). The FSM enters WAIT_SEL and counts SEL_LATENCY cycles from the all-ones cycle.
- On the count cycle, sample select_i:
  - flip_slot_o = select_i.
  - flip_var_o = var[select_i]. If select_i ≥ NSAT, flip_var_o=0.
  - Go to DONE.
- DONE: done_o=1 for 1 cycle, then IDLE.
- flip_var_o/flip_slot_o hold until the next start.
- break_values_valid_o is stable from start acceptance through the all-ones cycle; it clears to 0 on return to IDLE.
- start_i outside IDLE is ignored; no queuing.
- Reset (any state, mid-run included): state IDLE, tag pipeline flushed.
  - Reset values: ready_o=1; mem_rd_o=0; mem_addr_o=0; clause_broken_o=0; mask_bits_o=0; break_values_valid_o=0; wren_o=0; done_o=0; flip_var_o=0; flip_slot_o=0.
  - No wren pulse may escape after reset.

## Timing
Start accepted at cycle 0; L=BVC_LATENCY; SL=SEL_LATENCY.
- Fetch slot k: cycle 1+k. Memory data: 2+k. clause_broken_o valid: 3+k.
- wren_o one-hot k: cycle 3+k+L. All-ones: cycle 2+NSAT+L.
- wren_o=0 from cycle 3+NSAT+L.
- select_i sampled at cycle 2+NSAT+L+SL.
- done_o at cycle 3+NSAT+L+SL. ready_o at 4+NSAT+L+SL.
- Defaults (NSAT=3, L=1, SL=1):
  - Fetches at 1, 2, 3.
  - wren_o = 01 at 4, 10 at 5, 11 at 6, 00 at 7.
  - Sample at 7, done at 8, ready at 9.
- Throughput: one clause per 9 cycles. ready_o is low from cycle 1 to 8.
- All-empty clause: done_o at cycle 1, ready_o at cycle 2.

## Test plan
- Reset: all outputs at their reset values, ready_o=1.
- Nominal run, vars {5,9,17}, memory returns distinct patterns, select_i=2 at cycle 7:
  - mem_addr 5/9/17 at cycles 1–3.
  - wren 01/10/11/00 at cycles 4–7.
  - clause_broken_o matches memory one cycle after each return.
  - done_o at 8, flip_var_o=17, flip_slot_o=2.
- Empty slot, vars {0,4,6}:
  - No mem_rd_o at cycle 1; clause_broken_o=0 at cycle 3.
  - break_values_valid_o=110; wren sequence unchanged.
- All-empty clause {0,0,0}: done_o at cycle 1, flip_var_o=0, wren_o never nonzero.
- Reset asserted at cycle 5 mid-run: wren_o=0 from cycle 6 on, no done_o, ready_o=1; a new start is accepted normally.
- start_i held high continuously: second clause accepted only at cycle 9, its first fetch at cycle 10. Also set SEL_LATENCY=2 and verify select_i is sampled at cycle 8.
